// File: rtl/rps_gfx_pkg.sv
// Shared encodings for the rock-paper-scissors graphics blocks: image choices,
// palette entries and the panel blitter FSM state.
package rps_gfx_pkg;

  localparam logic [1:0] CHOICE_ROCK    = 2'b00;
  localparam logic [1:0] CHOICE_SCISSOR = 2'b01;
  localparam logic [1:0] CHOICE_PAPER   = 2'b10;
  localparam logic [1:0] CHOICE_BLANK   = 2'b11;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rps_panel_blitter_if.sv
// Graphics bus of the panel blitter: image ROM lookup plus the vga_adapter pixel write port.
// Protocol: rom_q is valid exactly one cycle after rom_addr/rom_sel; x/y/colour are meaningful only while plot=1.
interface rps_panel_blitter_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_sel;
  logic              rom_q;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [2:0]        colour;
  logic              plot;

  modport master (output rom_addr, rom_sel, x, y, colour, plot, input rom_q);
  modport slave  (input rom_addr, rom_sel, x, y, colour, plot, output rom_q);
endinterface

// File: rtl/rps_raster_counter.sv
// Raster walker for the panel blitter: lx/ly/panel counters that skip masked-off panels,
// with running x and row bases so no multiplier is needed.
module rps_raster_counter #(
  parameter  int NUM_PANELS = 2,
  parameter  int PANEL_W    = 80,
  parameter  int PANEL_H    = 120,
  parameter  int X_W        = 8,
  parameter  int ADDR_W     = 14,
  localparam int LX_W       = $clog2(PANEL_W),
  localparam int LY_W       = $clog2(PANEL_H),
  localparam int P_W        = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [NUM_PANELS-1:0] load_mask,
  output logic [LX_W-1:0]       lx,
  output logic [LY_W-1:0]       ly,
  output logic [P_W-1:0]        panel,
  output logic [X_W-1:0]        panel_base,
  output logic [ADDR_W-1:0]     row_base,
  output logic                  last
);

  logic [LX_W-1:0]       lx_q, lx_d;
  logic [LY_W-1:0]       ly_q, ly_d;
  logic [P_W-1:0]        panel_q, panel_d;
  logic [X_W-1:0]        base_q, base_d;
  logic [ADDR_W-1:0]     row_q, row_d;
  logic [NUM_PANELS-1:0] mask_q, mask_d;

  logic                  first_found, next_found;
  logic [P_W-1:0]        first_p, next_p;
  logic [X_W-1:0]        first_base, next_base, first_acc, next_acc;
  logic                  lx_end, ly_end;

  // Both searches walk the panels left to right, accumulating PANEL_W per step.
  always_comb begin
    first_found = 1'b0;
    first_p     = '0;
    first_base  = '0;
    first_acc   = '0;
    next_found  = 1'b0;
    next_p      = panel_q;
    next_base   = base_q;
    next_acc    = '0;
    for (int i = 0; i < NUM_PANELS; i++) begin
      if (!first_found && load_mask[i]) begin
        first_found = 1'b1;
        first_p     = P_W'(i);
        first_base  = first_acc;
      end
      if (!next_found && mask_q[i] && (i > int'(panel_q))) begin
        next_found = 1'b1;
        next_p     = P_W'(i);
        next_base  = next_acc;
      end
      first_acc = first_acc + X_W'(PANEL_W);
      next_acc  = next_acc + X_W'(PANEL_W);
    end
  end

  assign lx_end = (lx_q == LX_W'(PANEL_W - 1));
  assign ly_end = (ly_q == LY_W'(PANEL_H - 1));

  always_comb begin
    lx_d    = lx_q;
    ly_d    = ly_q;
    panel_d = panel_q;
    base_d  = base_q;
    row_d   = row_q;
    mask_d  = mask_q;
    if (load) begin
      lx_d    = '0;
      ly_d    = '0;
      row_d   = '0;
      panel_d = first_p;
      base_d  = first_base;
      mask_d  = load_mask;
    end else if (advance) begin
      if (!lx_end) begin
        lx_d = lx_q + LX_W'(1);
      end else begin
        lx_d = '0;
        if (!ly_end) begin
          ly_d  = ly_q + LY_W'(1);
          row_d = row_q + ADDR_W'(PANEL_W);
        end else begin
          ly_d    = '0;
          row_d   = '0;
          panel_d = next_p;
          base_d  = next_base;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lx_q    <= '0;
      ly_q    <= '0;
      panel_q <= '0;
      base_q  <= '0;
      row_q   <= '0;
      mask_q  <= '0;
    end else begin
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      panel_q <= panel_d;
      base_q  <= base_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
    end
  end

  assign lx         = lx_q;
  assign ly         = ly_q;
  assign panel      = panel_q;
  assign panel_base = base_q;
  assign row_base   = row_q;
  assign last       = lx_end && ly_end && !next_found;

endmodule

// File: rtl/rps_panel_blitter.sv
// Multi-panel image blitter: rasters the enabled panels through a 1-cycle ROM and
// emits plot/x/y/colour to the VGA adapter, with a start/busy/done handshake.
module rps_panel_blitter
  import rps_gfx_pkg::*;
#(
  parameter int                      NUM_PANELS = 2,
  parameter int                      PANEL_W    = 80,
  parameter int                      PANEL_H    = 120,
  parameter int                      X_W        = 8,
  parameter int                      Y_W        = 7,
  parameter int                      ADDR_W     = 14,
  parameter logic [2:0]              FG_COLOUR  = COLOUR_GREEN,
  parameter logic [3*NUM_PANELS-1:0] BG_COLOURS = {COLOUR_BLACK, COLOUR_WHITE}
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*NUM_PANELS-1:0] choices,
  input  logic [NUM_PANELS-1:0]   panel_en,
  output logic                    busy,
  output logic                    done,
  output state_t                  dbg_state,
  rps_panel_blitter_if.master     gfx
);

  localparam int LX_W = $clog2(PANEL_W);
  localparam int LY_W = $clog2(PANEL_H);
  localparam int P_W  = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;

  state_t state_q;
  logic   busy_q, done_q;

  logic [2*NUM_PANELS-1:0] choices_q, choices_d;
  logic [LX_W-1:0]         lx;
  logic [LY_W-1:0]         ly;
  logic [P_W-1:0]          panel;
  logic [X_W-1:0]          panel_base;
  logic [ADDR_W-1:0]       row_base;
  logic                    last;
  logic                    accept;
  logic [1:0]              rom_sel;

  logic                    s1_valid_q, s1_valid_d;
  logic [X_W-1:0]          s1_x_q, s1_x_d;
  logic [Y_W-1:0]          s1_y_q, s1_y_d;
  logic [P_W-1:0]          s1_panel_q, s1_panel_d;
  logic                    s1_blank_q, s1_blank_d;
  logic [2:0]              bg;

  logic                    plot_q, plot_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [2:0]              colour_q, colour_d;

  assign accept = (state_q == ST_IDLE) && start;

  rps_raster_counter #(
    .NUM_PANELS (NUM_PANELS),
    .PANEL_W    (PANEL_W),
    .PANEL_H    (PANEL_H),
    .X_W        (X_W),
    .ADDR_W     (ADDR_W)
  ) u_raster (
    .clk        (CLOCK_50),
    .rst        (reset),
    .load       (accept),
    .advance    (state_q == ST_SCAN),
    .load_mask  (panel_en),
    .lx         (lx),
    .ly         (ly),
    .panel      (panel),
    .panel_base (panel_base),
    .row_base   (row_base),
    .last       (last)
  );

  // busy covers the done cycle, which is one edge behind the DONE state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          busy_q <= start;
          if (start) state_q <= (panel_en == '0) ? ST_DRAIN : ST_SCAN;
        end
        ST_SCAN: begin
          busy_q <= 1'b1;
          if (last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          busy_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: begin
          busy_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 0 is the counter itself; stage 1 tracks the pixel while the ROM answers.
  always_comb begin
    choices_d  = accept ? choices : choices_q;
    rom_sel    = choices_q[2*int'(panel) +: 2];
    s1_valid_d = (state_q == ST_SCAN);
    s1_x_d     = panel_base + X_W'(lx);
    s1_y_d     = Y_W'(ly);
    s1_panel_d = panel;
    s1_blank_d = (rom_sel == CHOICE_BLANK);
    bg         = BG_COLOURS[3*int'(s1_panel_q) +: 3];
    colour_d   = (s1_blank_q || gfx.rom_q) ? bg : FG_COLOUR;
    plot_d     = s1_valid_q;
    x_d        = s1_x_q;
    y_d        = s1_y_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      choices_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_panel_q <= '0;
      s1_blank_q <= 1'b0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      choices_q  <= choices_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_panel_q <= s1_panel_d;
      s1_blank_q <= s1_blank_d;
      plot_q     <= plot_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
    end
  end

  assign gfx.rom_addr = row_base + ADDR_W'(lx);
  assign gfx.rom_sel  = rom_sel;
  assign gfx.plot     = plot_q;
  assign gfx.x        = x_q;
  assign gfx.y        = y_q;
  assign gfx.colour   = colour_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rps_panel_blitter.sv
// Scoreboard bench for rps_panel_blitter: frames are pushed as expected pixel streams,
// a negedge monitor pops and compares every plot and every done pulse.
module tb_rps_panel_blitter;
  import rps_gfx_pkg::*;

  localparam int PW   = 80;
  localparam int PH   = 120;
  localparam int NPIX = PW * PH;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] choices = '0;
  logic [1:0] panel_en = '0;
  logic       busy, done;
  state_t     dbg_state;
  logic       force0 = 1'b0;

  rps_panel_blitter_if #(.X_W(8), .Y_W(7), .ADDR_W(14)) gfx ();

  rps_panel_blitter dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .choices   (choices),
    .panel_en  (panel_en),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .gfx       (gfx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model (registered, 1-cycle latency) ----------------
  function automatic logic rom_fn(input logic [1:0] sel, input logic [13:0] a);
    case (sel)
      2'b00:   return a[0] ^ a[7];
      2'b01:   return a[2];
      2'b10:   return (a % 5) == 0;
      default: return a[1];
    endcase
  endfunction

  always @(posedge clk) gfx.rom_q <= force0 ? 1'b0 : rom_fn(gfx.rom_sel, gfx.rom_addr);

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int          done_cq[$];
  int          errors = 0;
  int          checks = 0;
  int          plots = 0;
  int          dones = 0;
  logic [17:0] mon_got, mon_exp;
  int          mon_done_exp;

  function automatic logic [2:0] bg_of(input int p);
    return (p == 0) ? 3'b111 : 3'b000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [3:0] ch, input logic [1:0] en, input logic f0);
    for (int p = 0; p < 2; p++) begin
      if (en[p]) begin
        for (int yy = 0; yy < PH; yy++) begin
          for (int xx = 0; xx < PW; xx++) begin
            logic [1:0] c;
            logic       r;
            logic [2:0] col;
            c   = ch[2*p +: 2];
            r   = f0 ? 1'b0 : rom_fn(c, 14'(yy * PW + xx));
            col = (c == 2'b11 || r) ? bg_of(p) : 3'b010;
            exp_q.push_back({8'(p * PW + xx), 7'(yy), col});
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (gfx.plot) begin
        plots++;
        checks++;
        mon_got = {gfx.x, gfx.y, gfx.colour};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL plot_unexpected: got x=%0d y=%0d colour=%0b, expected no plot", gfx.x, gfx.y, gfx.colour);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL plot: got x=%0d y=%0d colour=%0b expected x=%0d y=%0d colour=%0b",
                     mon_got[17:10], mon_got[9:3], mon_got[2:0], mon_exp[17:10], mon_exp[9:3], mon_exp[2:0]);
          end
        end
      end
      if (done) begin
        dones++;
        if (done_cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_done_exp = done_cq.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_done_exp));
          check("frame_drained", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [3:0] ch, input logic [1:0] en, input logic f0);
    @(negedge clk);
    force0   = f0;
    choices  = ch;
    panel_en = en;
    start    = 1'b1;
    push_frame(ch, en, f0);
    done_cq.push_back(cyc + (int'(en[0]) + int'(en[1])) * NPIX + 3);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int d0;
    d0 = dones;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dones != d0) break;
    end
    checks++;
    if (dones == d0) begin
      errors++;
      $display("FAIL frame_timeout: got no done within %0d cycles, expected one", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, d0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_plot", 32'(gfx.plot), 0);
    check("rst_xy_colour", {gfx.x, gfx.y, gfx.colour}, 0);
    check("rst_rom", {gfx.rom_addr, gfx.rom_sel}, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    // Full frame: panel0 rock on white, panel1 scissor on black.
    start_frame(4'b01_00, 2'b11, 1'b0);
    wait_frame(20000);

    // Only panel1 redrawn: all x in 80..159.
    start_frame(4'b10_01, 2'b10, 1'b0);
    wait_frame(10000);

    // Blank panel0 with ink forced on everywhere: every pixel stays background.
    start_frame(4'b00_11, 2'b01, 1'b1);
    wait_frame(10000);

    // Empty mask: no plots, done at start+3, busy start+1..start+3.
    p0 = plots;
    d0 = dones;
    start_frame(4'b00_00, 2'b00, 1'b0);
    check("zero_busy_1", 32'(busy), 1);
    @(negedge clk);
    check("zero_busy_2", 32'(busy), 1);
    @(negedge clk);
    check("zero_busy_3", 32'(busy), 1);
    @(negedge clk);
    check("zero_busy_off", 32'(busy), 0);
    check("zero_no_plots", 32'(plots - p0), 0);
    check("zero_one_done", 32'(dones - d0), 1);

    // Reset mid-frame around pixel 5000, then a full frame.
    p0 = plots;
    d0 = dones;
    start_frame(4'b10_00, 2'b11, 1'b0);
    for (int i = 0; i < 6000 && (plots - p0) < 5000; i++) @(negedge clk);
    check("mid_reset_reached", 32'((plots - p0) >= 5000), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_plot", 32'(gfx.plot), 0);
    check("mid_reset_busy", 32'(busy), 0);
    check("mid_reset_done", 32'(done), 0);
    check("mid_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    done_cq.delete();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_reset_no_done", 32'(dones - d0), 0);
    start_frame(4'b01_10, 2'b11, 1'b0);
    wait_frame(20000);

    // Start pulse and choice churn mid-frame are ignored.
    d0 = dones;
    start_frame(4'b10_01, 2'b10, 1'b0);
    repeat (100) @(negedge clk);
    choices  = 4'b01_11;
    panel_en = 2'b11;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (37) @(negedge clk);
      choices = 4'(i * 5 + 3);
    end
    wait_frame(10000);
    repeat (20) @(negedge clk);
    check("ignore_one_done", 32'(dones - d0), 1);
    check("final_exp_empty", 32'(exp_q.size()), 0);
    check("final_done_empty", 32'(done_cq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
